// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI mode-0 master that moves one 16-bit word to or from a
// 23LC-style serial SRAM. A frame is 40 bits: 8-bit command (0x03 read,
// 0x02 write), 16-bit byte address ({word address, 1'b0}) and 16 data bits.
// busy_o stalls the CPU control FSM until the frame has finished.

module spi_mem_ctrl #(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        start_i,
   input  logic        rwb_i,
   input  logic [14:0] addr_i,
   input  logic [15:0] wdata_i,
   input  logic        miso_i,
   output logic        sclk_o,
   output logic        mosi_o,
   output logic        csb_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] data_o
);

   localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]      BIT_LAST = 6'd39;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      DONE
   } state_t;

   state_t           state;
   logic [39:0]      shreg;
   logic [39:0]      new_frame;
   logic [5:0]       bit_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic             rd_q;

   // Frame loaded at accept; the data field carries wdata_i even for reads.
   always_comb begin
      new_frame = {(rwb_i ? 8'h03 : 8'h02), addr_i, 1'b0, wdata_i};
   end

   // The FSM must stall in the very cycle it raises start, so busy is
   // combinational in IDLE and drops only for the DONE cycle.
   always_comb begin
      busy_o = 1'b1;
      if (state == IDLE) begin
         busy_o = start_i;
      end else if (state == DONE) begin
         busy_o = 1'b0;
      end
   end

   // Sequencer: SCLK low/high phases of CLK_DIV cycles each, MOSI updated on
   // the falling SCLK edge, MISO shifted in on the rising SCLK edge.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         rd_q    <= 1'b0;
         sclk_o  <= 1'b0;
         mosi_o  <= 1'b0;
         csb_o   <= 1'b1;
         done_o  <= 1'b0;
         data_o  <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               csb_o   <= 1'b1;
               sclk_o  <= 1'b0;
               div_cnt <= '0;
               bit_cnt <= '0;
               if (start_i) begin
                  rd_q   <= rwb_i;
                  shreg  <= new_frame;
                  mosi_o <= new_frame[39];
                  csb_o  <= 1'b0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (!sclk_o) begin
                     sclk_o <= 1'b1;
                     shreg  <= {shreg[38:0], miso_i};
                  end else begin
                     sclk_o <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= HOLD;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        mosi_o  <= shreg[39];
                     end
                  end
               end
            end
            HOLD: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  csb_o   <= 1'b1;
                  mosi_o  <= 1'b0;
                  done_o  <= 1'b1;
                  state   <= DONE;
                  if (rd_q) begin
                     data_o <= shreg[15:0];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

SPI master that executes one 16-bit word read or write against an external serial SRAM (23LC-style, SPI mode 0, READ 0x03 / WRITE 0x02, 16-bit byte address). It sits directly downstream of the CPU control FSM: it consumes that FSM's spiStart/rwb requests and returns a busy signal that drives the FSM's halt_i, stalling the FSM until the transfer completes. Address and write-data muxing (PC vs. A, D/ALU result) happen outside this block; fetched words go to the instruction/A-load path via data_o.

## Interface
- CLK_DIV, default 1: SCLK half-period in clk cycles (≥1); SCLK period = 2·CLK_DIV clk.
- clk  in  1  system clock; all state on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- start_i  in  1  transfer request (FSM spiStart_o), level, held until busy_o drops.
- rwb_i  in  1  1 = read, 0 = write; sampled at accept only.
- addr_i  in  15  word address; sampled at accept only.
- wdata_i  in  16  write data; sampled at accept only.
- miso_i  in  1  serial data from SRAM.
- sclk_o  out  1  SPI clock, idles low.
- mosi_o  out  1  serial data to SRAM.
- csb_o  out  1  SRAM chip select, active low.
- busy_o  out  1  stall to FSM halt_i.
- done_o  out  1  one-cycle completion pulse.
- data_o  out  16  last word read.

## Operation
- States: IDLE, SHIFT, HOLD, DONE.
- IDLE: csb_o=1, sclk_o=0. If start_i=1: latch rwb_i, addr_i, wdata_i; load 40-bit shift register {cmd, addr_i, 1'b0, wdata_i}, cmd = 0x03 (read) / 0x02 (write); → SHIFT. busy_o = start_i in IDLE (combinational, so the FSM stalls in the same cycle it asserts start).
- SHIFT: csb_o=0; 40 bits MSB first. Each bit: sclk_o low CLK_DIV cycles, then high CLK_DIV cycles. mosi_o = current shift-register MSB, changes only while sclk_o low (at the falling edge). miso_i sampled on the clk edge that raises sclk_o. After the 40th high phase → HOLD. busy_o=1.
- HOLD: sclk_o=0, csb_o=0 for CLK_DIV cycles (CS hold time), then → DONE. busy_o=1.
- DONE: exactly one cycle; csb_o=1, busy_o=0, done_o=1. If read, data_o = last 16 miso bits sampled (bits 24..39 of frame), updated on the edge entering DONE; write leaves data_o unchanged. start_i ignored here (the FSM advances on this edge, so its start for the old state is still visible). → IDLE.
- Bit counter 6 bits (0..39), divider counter ⌈log2(CLK_DIV)⌉+1 bits; no wrap outside these ranges.
- Input changes after accept have no effect on the frame in progress.
- Byte address = {addr_i, 1'b0}; addr_i = 0x7FFF → 0xFFFE.

## Timing
- Reset (async, any state, including mid-frame): state=IDLE, csb_o=1, sclk_o=0, mosi_o=0, done_o=0, data_o=0x0000, counters 0; busy_o then equals start_i. SRAM sees CS rise, aborting the frame; write may be partial.
- Accept cycle = cycle in IDLE with start_i=1 (busy_o=1 already).
- busy_o high for 1 + 81·CLK_DIV consecutive cycles (CLK_DIV=1: 82), then low for the DONE cycle.
- First SCLK rising edge CLK_DIV cycles after csb_o falls; first mosi bit valid when csb_o falls.
- csb_o high minimum 2 cycles between frames (DONE + IDLE) when start_i is held continuously.
- data_o stable from DONE until the next read's DONE.

## Test plan
- Read, CLK_DIV=1, addr_i=0x0005, SRAM model returns 0xBEEF: MOSI bits = 0x03, 0x000A; busy_o high 82 cycles; done_o one pulse; data_o=0xBEEF in DONE cycle; 40 SCLK rising edges.
- Write, CLK_DIV=1, addr_i=0x7FFF, wdata_i=0x1234: MOSI = 0x02, 0xFFFE, 0x1234; model memory bytes 0xFFFE/0xFFFF = 0x12/0x34; data_o keeps prior value.
- start_i held high across two transfers (read 0x0001 then write, inputs changed mid-frame): exactly one frame per accept; mid-frame input changes ignored; csb_o high ≥2 cycles between frames.
- CLK_DIV=3 read: SCLK period 6 clk, high/low 3 each; busy_o high 244 cycles; mosi only changes while sclk_o low; correct data_o.
- resetb pulled low at bit 20 of a write: csb_o=1, sclk_o=0, busy_o=start_i, data_o=0 immediately; after release with start_i=1, a fresh full 40-bit frame starts.
